// File: rtl/rv32_div_pkg.sv
// Shared definitions for the iterative RV32M divider.
// Holds the default operand width, the funct3[1:0] operation encodings,
// the control-FSM state enumeration and the INT_MIN / ALL_ONES constants.
// No ports (package).
package rv32_div_pkg;

    localparam int DEF_XLEN = 32;

    // funct3[1:0] of the RV32M divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    localparam logic [DEF_XLEN-1:0] INT_MIN  = {1'b1, {(DEF_XLEN-1){1'b0}}};
    localparam logic [DEF_XLEN-1:0] ALL_ONES = {DEF_XLEN{1'b1}};

endpackage

// File: rtl/rv32_div_iter_if.sv
// Request/response bundle between the execute stage and the divider.
// Signals:
//   start  - request, sampled only while the divider is idle
//   op     - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1    - dividend, rs2 - divisor (latched on acceptance)
//   flush  - kill the in-flight operation
//   busy   - high in every state except idle (drives the pipeline stall)
//   done   - one-cycle pulse, result valid in the same cycle
//   result - quotient or remainder, held until the next completed operation
// Handshake: a request is accepted on a rising clk edge where start=1,
// flush=0 and busy=0. Exactly one done pulse follows each accepted request
// unless it is flushed or reset first; start while busy is ignored.
// Modports: master (execute stage) and slave (divider).
interface rv32_div_iter_if #(
    parameter int XLEN = rv32_div_pkg::DEF_XLEN
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/rv32_div_step.sv
// One restoring radix-2 division step (purely combinational).
// Ports:
//   rem_quo      in  2*XLEN  {partial remainder, quotient/dividend shift reg}
//   divisor      in  XLEN    unsigned divisor magnitude
//   rem_quo_next out 2*XLEN  {rem,quo} after one shift + trial subtract
module rv32_div_step
    import rv32_div_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [2*XLEN-1:0] rem_quo,
    input  logic [XLEN-1:0]   divisor,
    output logic [2*XLEN-1:0] rem_quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // remainder shifted left with the quotient MSB brought in; one extra
        // bit because the shifted remainder can reach 2*divisor-1
        shifted = rem_quo[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, divisor};
        if (diff[XLEN]) begin
            rem_quo_next = {shifted[XLEN-1:0], rem_quo[XLEN-2:0], 1'b0};
        end else begin
            rem_quo_next = {diff[XLEN-1:0], rem_quo[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/rv32_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Sequence IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> DONE -> IDLE;
// done pulses 34 cycles after the accepting edge for XLEN=32.
// Optional feature macro RV32_DIV_EARLY_OUT_EN: divide-by-zero and signed
// overflow are resolved in IDLE and jump straight to DONE.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-high reset
//   bus       slave modport of rv32_div_iter_if (start/op/rs1/rs2/flush,
//             busy/done/result)
//   dbg_state out current FSM state
module rv32_div_iter
    import rv32_div_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic           clk,
    input  logic           rst,
    rv32_div_iter_if.slave bus,
    output div_state_e     dbg_state
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};

    div_state_e        state;
    div_state_e        state_next;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] step_next;
    logic              accept;
    logic              early;
    logic              is_signed;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN:0]     spec_fix;
    logic [XLEN-1:0]   fix_value;

    // {hit, value}: RISC-V defined results that bypass the normal sign fixup
    function automatic logic [XLEN:0] special_case(input logic [1:0]      f_op,
                                                   input logic [XLEN-1:0] f_a,
                                                   input logic [XLEN-1:0] f_b);
        logic [XLEN:0] r;
        r = '0;
        if (f_b == '0) begin
            r = {1'b1, (f_op[1] ? f_a : ONES_VAL)};
        end else if (!f_op[0] && f_a == MIN_VAL && f_b == ONES_VAL) begin
            r = {1'b1, (f_op[1] ? {XLEN{1'b0}} : MIN_VAL)};
        end
        return r;
    endfunction

    assign accept = (state == ST_IDLE) && bus.start && !bus.flush;

`ifdef RV32_DIV_EARLY_OUT_EN
    logic [XLEN:0] spec_in;
    assign spec_in = special_case(bus.op, bus.rs1, bus.rs2);
    assign early   = spec_in[XLEN];
`else
    assign early = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (state != ST_IDLE && bus.flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_next = early ? ST_DONE : ST_PREP;
                ST_PREP: state_next = ST_ITER;
                ST_ITER: if (cnt_q == CNT_W'(XLEN-1)) state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = (state != ST_IDLE);
        bus.done = (state == ST_DONE);
    end

    assign bus.result = result_q;
    assign dbg_state  = state;

    // ---------------- datapath ----------------
    assign is_signed = !op_q[0];
    assign abs_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
    assign quo_fix   = q_neg_q ? -quo_q : quo_q;
    assign rem_fix   = r_neg_q ? -rem_q : rem_q;
    assign spec_fix  = special_case(op_q, a_q, b_q);
    assign fix_value = spec_fix[XLEN] ? spec_fix[XLEN-1:0]
                                      : (op_q[1] ? rem_fix : quo_fix);

    rv32_div_step #(.XLEN(XLEN)) u_step (
        .rem_quo      ({rem_q, quo_q}),
        .divisor      (dvs_q),
        .rem_quo_next (step_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        a_q  <= bus.rs1;
                        b_q  <= bus.rs2;
`ifdef RV32_DIV_EARLY_OUT_EN
                        if (early) result_q <= spec_in[XLEN-1:0];
`endif
                    end
                end
                ST_PREP: begin
                    q_neg_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    r_neg_q <= is_signed && a_q[XLEN-1];
                    rem_q   <= '0;
                    quo_q   <= abs_a;
                    dvs_q   <= abs_b;
                    cnt_q   <= '0;
                end
                ST_ITER: begin
                    {rem_q, quo_q} <= step_next;
                    cnt_q          <= cnt_q + 1'b1;
                end
                ST_FIX: begin
                    // a flush here must leave the previous result visible
                    if (!bus.flush) result_q <= fix_value;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_div_iter.sv
// Self-checking bench for rv32_div_iter: directed corner cases, random
// operations against an arithmetic reference model, flush, reset and
// start-while-busy scenarios.
module tb_rv32_div_iter;
    import rv32_div_pkg::*;

`ifdef RV32_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int LIMIT = 80;

    logic       clk;
    logic       rst;
    div_state_e dbg_state;
    logic [31:0] last_result;
    int n_checks;
    int n_fail;

    rv32_div_iter_if #(.XLEN(32)) bus ();

    rv32_div_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_DIVU: return 32'(ua / ub);
            OP_REM:  return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit sp;
        sp = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (sp && EARLY) ? 0 : 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one request and watches until busy drops. done_lat counts
    // cycles after the accepting edge (0 = the cycle right after it).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit junk_start,
                          output logic [31:0] res, output int done_lat,
                          output int done_cnt, output int busy_cnt);
        res = 32'd0;
        done_lat = -1;
        done_cnt = 0;
        busy_cnt = 0;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.rs1   = $urandom();
        bus.rs2   = $urandom();
        bus.op    = 2'($urandom_range(0, 3));
        for (int n = 0; n < LIMIT; n++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat = n;
                    res = bus.result;
                end
            end
            if (!bus.busy) break;
            if (junk_start && n >= 5 && (done_lat < 0 || n == done_lat)) begin
                bus.start = 1'b1;
                bus.rs1   = 32'd1;
                bus.rs2   = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = 32'd0;
        bus.rs2   = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        n_checks++;
        if (bus.result !== 32'd0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", bus.result);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        last_result = 32'd0;
    endtask

    localparam logic [1:0]  D_OP  [8] = '{OP_DIV, OP_REM, OP_REMU, OP_DIVU,
                                          OP_DIV, OP_REMU, OP_DIV, OP_REM};
    localparam logic [31:0] D_A   [8] = '{32'd20, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                          32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
    localparam logic [31:0] D_B   [8] = '{32'hFFFF_FFFD, 32'd3, 32'd2, 32'd2,
                                          32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] D_EXP [8] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd1, 32'h7FFF_FFFF,
                                          32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0};

    task automatic test_directed();
        logic [31:0] res;
        int lat, dcnt, bcnt, elat;
        for (int i = 0; i < 8; i++) begin
            run_op(D_OP[i], D_A[i], D_B[i], 1'b0, res, lat, dcnt, bcnt);
            elat = exp_latency(D_OP[i], D_A[i], D_B[i]);
            n_checks++;
            if (res !== D_EXP[i]) begin
                n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, D_EXP[i]);
            end
            n_checks++;
            if (lat !== elat) begin
                n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, elat);
            end
            n_checks++;
            if (bcnt !== elat + 1) begin
                n_fail++; $display("FAIL directed_busy[%0d]: got %0d want %0d", i, bcnt, elat + 1);
            end
            n_checks++;
            if (dcnt !== 1) begin
                n_fail++; $display("FAIL directed_done_count[%0d]: got %0d want 1", i, dcnt);
            end
            last_result = D_EXP[i];
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [1:0] op;
        int lat, dcnt, bcnt;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = pick();
            b   = pick();
            exp = model(op, a, b);
            run_op(op, a, b, 1'b0, res, lat, dcnt, bcnt);
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp);
            end
            n_checks++;
            if (lat !== exp_latency(op, a, b)) begin
                n_fail++;
                $display("FAIL random_latency op=%0d: got %0d want %0d", op, lat, exp_latency(op, a, b));
            end
            n_checks++;
            if (dcnt !== 1) begin
                n_fail++; $display("FAIL random_done_count: got %0d want 1", dcnt);
            end
            tick();
            n_checks++;
            if (bus.result !== exp) begin
                n_fail++; $display("FAIL random_result_hold: got %h want %h", bus.result, exp);
            end
            last_result = exp;
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, dcnt, bcnt;
        bit saw_done;
        saw_done = 1'b0;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy);
        end
        for (int n = 0; n < 40; n++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_done: got %b want 0", saw_done);
        end
        n_checks++;
        if (bus.result !== last_result) begin
            n_fail++; $display("FAIL flush_result_kept: got %h want %h", bus.result, last_result);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, res, lat, dcnt, bcnt);
        n_checks++;
        if (res !== 32'd14) begin
            n_fail++; $display("FAIL flush_rerun_result: got %h want %h", res, 32'd14);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++; $display("FAIL flush_rerun_latency: got %0d want 34", lat);
        end
        last_result = 32'd14;
    endtask

    task automatic test_flush_start();
        bit saw;
        saw = 1'b0;
        bus.op    = OP_DIV;
        bus.rs1   = 32'd50;
        bus.rs2   = 32'd5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_busy: got %b want 0", bus.busy);
        end
        for (int n = 0; n < 40; n++) begin
            if (bus.done || bus.busy) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_activity: got %b want 0", saw);
        end
        n_checks++;
        if (bus.result !== last_result) begin
            n_fail++; $display("FAIL flush_start_result: got %h want %h", bus.result, last_result);
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res;
        int lat, dcnt, bcnt;
        bus.op    = OP_DIV;
        bus.rs1   = 32'd1000;
        bus.rs2   = -32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_done: got %b want 0", bus.done);
        end
        n_checks++;
        if (bus.result !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_result: got %h want 0", bus.result);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, ST_IDLE);
        end
        tick();
        rst = 1'b0;
        last_result = 32'd0;
        run_op(OP_REM, 32'd1000, -32'd7, 1'b0, res, lat, dcnt, bcnt);
        n_checks++;
        if (res !== model(OP_REM, 32'd1000, -32'd7)) begin
            n_fail++;
            $display("FAIL rst_recover_result: got %h want %h", res, model(OP_REM, 32'd1000, -32'd7));
        end
        last_result = res;
    endtask

    task automatic test_busy_start();
        logic [31:0] res;
        int lat, dcnt, bcnt;
        bit saw;
        saw = 1'b0;
        run_op(OP_DIV, 32'd1000, 32'd7, 1'b1, res, lat, dcnt, bcnt);
        n_checks++;
        if (res !== 32'd142) begin
            n_fail++; $display("FAIL busy_start_result: got %h want %h", res, 32'd142);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++; $display("FAIL busy_start_latency: got %0d want 34", lat);
        end
        n_checks++;
        if (bcnt !== 35) begin
            n_fail++; $display("FAIL busy_start_busy: got %0d want 35", bcnt);
        end
        for (int n = 0; n < 5; n++) begin
            if (bus.done || bus.busy) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_ignored: got %b want 0", saw);
        end
        n_checks++;
        if (bus.result !== 32'd142) begin
            n_fail++; $display("FAIL busy_start_hold: got %h want %h", bus.result, 32'd142);
        end
        last_result = 32'd142;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_result = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_flush_start();
        test_rst_mid();
        test_busy_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
